// File: rtl/tdm_demux.sv
// tdm_demux: receive-side time-division demultiplexer.
// A serial stream of WIDTH-bit words is split into four parallel channels.
// In framed mode an internal slot counter, aligned by frame_sync, collects
// words into shadow registers, and the whole frame is published at once.
// In direct mode each word is steered straight to the channel named by
// {s2,s1}. All outputs are registered.
`timescale 1ns/1ps

module tdm_demux #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  input  logic             mode,
  input  logic             s1,
  input  logic             s2,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             out_valid,
  output logic             sync_err,
  output logic [1:0]       slot,
  output logic             locked
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Framer state and the registered copy of mode used to spot mode changes.
  state_t     state_reg, state_next;
  logic [1:0] slot_reg, slot_next;
  logic       mode_q_reg;

  // Registered pulse outputs.
  logic out_valid_reg, out_valid_next;
  logic sync_err_reg, sync_err_next;

  // Per-cycle control decoded by the next-state logic.
  logic [2:0] shadow_we;   // write din into shadow slot 0..2
  logic       frame_done;  // slot-3 word arrived: publish the frame
  logic [3:0] direct_we;   // direct-mode write into channel 0..3

  // Effective state/slot after applying a mode-change flush. A change of
  // mode throws away any partial frame before the current word is handled.
  logic       mode_change;
  state_t     cur_state;
  logic [1:0] cur_slot;

  // Gathered views of the per-slot and per-channel registers.
  logic [WIDTH-1:0] shadow_q [3];
  logic [WIDTH-1:0] chan_q   [4];

  assign mode_change = (mode != mode_q_reg);
  assign cur_state   = mode_change ? HUNT : state_reg;
  assign cur_slot    = mode_change ? 2'd0 : slot_reg;

  // Framer state register, slot counter and mode history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= HUNT;
      slot_reg   <= 2'd0;
      mode_q_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      slot_reg   <= slot_next;
      mode_q_reg <= mode;
    end
  end

  // Next-state and control decode for both modes.
  always_comb begin
    state_next     = cur_state;
    slot_next      = cur_slot;
    shadow_we      = 3'b000;
    frame_done     = 1'b0;
    direct_we      = 4'b0000;
    out_valid_next = 1'b0;
    sync_err_next  = 1'b0;

    if (mode) begin
      // Direct mode keeps the framer parked so a return to framed mode
      // always starts hunting from a clean state.
      state_next = HUNT;
      slot_next  = 2'd0;
      if (din_valid) begin
        direct_we[{s2, s1}] = 1'b1;
        out_valid_next      = 1'b1;
      end
    end else if (din_valid) begin
      unique case (cur_state)
        HUNT: begin
          // Words before the first frame_sync carry no position: drop them.
          if (frame_sync) begin
            shadow_we[0] = 1'b1;
            slot_next    = 2'd1;
            state_next   = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_sync && (cur_slot != 2'd0)) begin
            // Sync arrived mid-frame: abandon the partial frame and
            // restart with this word as slot 0. Outputs are untouched.
            sync_err_next = 1'b1;
            shadow_we[0]  = 1'b1;
            slot_next     = 2'd1;
          end else if (cur_slot == 2'd3) begin
            // Last word of the frame goes straight to d alongside the
            // shadowed a..c, so the frame needs no extra cycle.
            frame_done     = 1'b1;
            out_valid_next = 1'b1;
            slot_next      = 2'd0;
          end else begin
            shadow_we[cur_slot] = 1'b1;
            slot_next           = cur_slot + 2'd1;
          end
        end
        default: begin
          state_next = HUNT;
          slot_next  = 2'd0;
        end
      endcase
    end
  end

  // Shadow registers hold slots 0..2 of the frame being assembled.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_shadow
      logic [WIDTH-1:0] shadow_reg;

      // Capture din into this slot when the framer selects it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow_reg <= '0;
        end else if (shadow_we[gi]) begin
          shadow_reg <= din;
        end
      end

      assign shadow_q[gi] = shadow_reg;
    end
  endgenerate

  // Output channel registers: loaded as a whole frame in framed mode, or
  // individually in direct mode. Channel 3 takes din itself on completion.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_chan
      logic [WIDTH-1:0] chan_reg;
      logic [WIDTH-1:0] frame_word;

      if (gi < 3) begin : g_from_shadow
        assign frame_word = shadow_q[gi];
      end else begin : g_from_din
        assign frame_word = din;
      end

      // Update this channel on frame completion or a direct write.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          chan_reg <= '0;
        end else if (frame_done) begin
          chan_reg <= frame_word;
        end else if (direct_we[gi]) begin
          chan_reg <= din;
        end
      end

      assign chan_q[gi] = chan_reg;
    end
  endgenerate

  // Single-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      sync_err_reg  <= 1'b0;
    end else begin
      out_valid_reg <= out_valid_next;
      sync_err_reg  <= sync_err_next;
    end
  end

  assign a         = chan_q[0];
  assign b         = chan_q[1];
  assign c         = chan_q[2];
  assign d         = chan_q[3];
  assign out_valid = out_valid_reg;
  assign sync_err  = sync_err_reg;
  assign slot      = slot_reg;
  assign locked    = (state_reg == LOCKED);

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: directed word sequences, a frame-level reference
// model built on a queue of collected words, a per-cycle compare process,
// and literal spot checks after the key transactions.
`timescale 1ns/1ps

module tb_tdm_demux;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         frame_sync = 1'b0;
  logic         mode = 1'b0;
  logic         s1 = 1'b0;
  logic         s2 = 1'b0;
  logic [W-1:0] a, b, c, d;
  logic         out_valid, sync_err, locked;
  logic [1:0]   slot;

  tdm_demux #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .frame_sync(frame_sync), .mode(mode), .s1(s1), .s2(s2),
    .a(a), .b(b), .c(c), .d(d), .out_valid(out_valid),
    .sync_err(sync_err), .slot(slot), .locked(locked)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ov_count = 0;
  int se_count = 0;

  // Reference model: frame holds the words collected so far in the
  // current frame; its size is the next slot.
  logic [W-1:0] exp_ch [4];
  logic [W-1:0] frame [$];
  bit           exp_ov = 1'b0;
  bit           exp_se = 1'b0;
  bit           m_locked = 1'b0;
  bit           m_mode = 1'b0;
  bit           mode_in = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) exp_ch[i] = '0;
    frame.delete();
    exp_ov = 1'b0;
    exp_se = 1'b0;
    m_locked = 1'b0;
    m_mode = 1'b0;
  endtask

  task automatic model_step(bit v, logic [W-1:0] dv, bit fs, bit md, logic [1:0] sel);
    exp_ov = 1'b0;
    exp_se = 1'b0;
    if (md != m_mode) begin
      frame.delete();
      m_locked = 1'b0;
    end
    m_mode = md;
    if (md) begin
      m_locked = 1'b0;
      frame.delete();
      if (v) begin
        exp_ch[sel] = dv;
        exp_ov = 1'b1;
      end
    end else if (v) begin
      if (!m_locked) begin
        if (fs) begin
          frame.delete();
          frame.push_back(dv);
          m_locked = 1'b1;
        end
      end else if (fs && frame.size() != 0) begin
        exp_se = 1'b1;
        frame.delete();
        frame.push_back(dv);
      end else begin
        frame.push_back(dv);
        if (frame.size() == 4) begin
          for (int i = 0; i < 4; i++) exp_ch[i] = frame[i];
          exp_ov = 1'b1;
          frame.delete();
        end
      end
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    check("a", a, exp_ch[0]);
    check("b", b, exp_ch[1]);
    check("c", c, exp_ch[2]);
    check("d", d, exp_ch[3]);
    check("out_valid", out_valid, exp_ov);
    check("sync_err", sync_err, exp_se);
    check("slot", slot, frame.size());
    check("locked", locked, m_locked);
    if (out_valid === 1'b1) ov_count++;
    if (sync_err === 1'b1) se_count++;
  end

  // One transaction: drive inputs away from the edge, let the edge take
  // them, then advance the model.
  task automatic cyc(bit v, logic [W-1:0] dv, bit fs, logic [1:0] sel);
    @(negedge clk);
    din_valid = v;
    din = dv;
    frame_sync = fs;
    mode = mode_in;
    {s2, s1} = sel;
    @(posedge clk);
    model_step(v, dv, fs, mode_in, sel);
    $display("txn t=%0t valid=%0b din=%h sync=%0b mode=%0b sel=%0d", $time, v, dv, fs, mode_in, sel);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    @(negedge clk);
    din_valid = 1'b0;
    frame_sync = 1'b0;
    #2 rst_n = 1'b0;
    #1 model_reset();
    check("rst_a", a, 0);
    check("rst_b", b, 0);
    check("rst_c", c, 0);
    check("rst_d", d, 0);
    check("rst_slot", slot, 0);
    check("rst_locked", locked, 0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("txn t=%0t reset pulse", $time);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset then one framed burst.
    cyc(1, 4'h1, 1, 0);
    cyc(1, 4'h2, 0, 0);
    cyc(1, 4'h3, 0, 0);
    cyc(1, 4'h4, 0, 0);
    #1;
    check("t1_ov", out_valid, 1);
    check("t1_abcd", {a, b, c, d}, 16'h1234);
    check("t1_slot", slot, 0);
    check("t1_locked", locked, 1);

    // HUNT ignores unsynced words.
    do_reset();
    cyc(1, 4'h7, 0, 0);
    cyc(1, 4'h8, 0, 0);
    #1 check("t2_hunt", locked, 0);
    ov_count = 0;
    cyc(1, 4'hA, 1, 0);
    cyc(1, 4'hB, 0, 0);
    cyc(1, 4'hC, 0, 0);
    cyc(1, 4'hD, 0, 0);
    #1 check("t2_abcd", {a, b, c, d}, 16'hABCD);
    cyc(0, 4'h0, 0, 0);
    #1 check("t2_ov_count", ov_count, 1);

    // Mid-frame resync.
    se_count = 0;
    cyc(1, 4'h1, 1, 0);
    cyc(1, 4'h2, 0, 0);
    cyc(1, 4'h9, 1, 0);
    #1 check("t3_sync_err", sync_err, 1);
    check("t3_hold", {a, b, c, d}, 16'hABCD);
    cyc(1, 4'h5, 0, 0);
    cyc(1, 4'h6, 0, 0);
    cyc(1, 4'h7, 0, 0);
    #1 check("t3_abcd", {a, b, c, d}, 16'h9567);
    cyc(0, 4'h0, 0, 0);
    #1 check("t3_se_count", se_count, 1);

    // Gapped frame then free-running frame without sync.
    ov_count = 0;
    se_count = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 4'(i + 1), (i == 0), 0);
      cyc(0, 4'h0, 0, 0);
      cyc(0, 4'h0, 0, 0);
    end
    #1 check("t4_abcd_first", {a, b, c, d}, 16'h1234);
    for (int i = 0; i < 4; i++) cyc(1, 4'(i + 5), 0, 0);
    cyc(0, 4'h0, 0, 0);
    #1;
    check("t4_abcd", {a, b, c, d}, 16'h5678);
    check("t4_ov_count", ov_count, 2);
    check("t4_se_count", se_count, 0);

    // Direct mode.
    mode_in = 1'b1;
    cyc(0, 4'h0, 0, 0);
    #1 check("t5_unlock", locked, 0);
    cyc(1, 4'hE, 0, 2'b10);
    #1 check("t5_c", c, 4'hE);
    check("t5_ov1", out_valid, 1);
    cyc(1, 4'h3, 1, 2'b01);
    #1;
    check("t5_abcd", {a, b, c, d}, 16'h53E8);
    check("t5_ov2", out_valid, 1);
    check("t5_se", sync_err, 0);
    check("t5_slot", slot, 0);
    check("t5_locked", locked, 0);

    // Async reset mid-frame, then a mode switch mid-frame.
    mode_in = 1'b0;
    cyc(0, 4'h0, 0, 0);
    cyc(1, 4'h1, 1, 0);
    cyc(1, 4'h2, 0, 0);
    do_reset();
    cyc(1, 4'h1, 1, 0);
    cyc(1, 4'h2, 0, 0);
    #1;
    check("t6_locked", locked, 1);
    check("t6_slot", slot, 2);
    mode_in = 1'b1;
    cyc(0, 4'h0, 0, 0);
    #1;
    check("t6_unlock", locked, 0);
    check("t6_no_ov", out_valid, 0);
    check("t6_slot0", slot, 0);
    check("t6_zero", {a, b, c, d}, 16'h0000);
    cyc(0, 4'h0, 0, 0);
    @(negedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
